// File: rtl/rv32i_mem_arbiter_if.sv
// Bundle of fetch, load/store and memory-port signals seen by rv32i_mem_arbiter.
// slave  : the arbiter's view (requests and memory read data in, acks and memory port out).
// master : the surrounding core/memory view.
interface rv32i_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_ack;
    logic [DATA_W-1:0]     i_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [DATA_W/8-1:0]   d_be;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_ack;
    logic [DATA_W-1:0]     d_rdata;

    logic                  m_en;
    logic                  m_we;
    logic [DATA_W/8-1:0]   m_be;
    logic [ADDR_W-1:0]     m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [DATA_W-1:0]     m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_be, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, m_en, m_we, m_be, m_addr, m_wdata
    );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Arbiter sharing one single-port synchronous memory between instruction fetch and the LSU.
// One transaction at a time: IDLE -> ISSUE -> (WAIT x MEM_LAT) -> RESP, stores skip WAIT.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin on contention; otherwise data beats fetch.
module rv32i_mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input logic               clk,
    input logic               rst,
    rv32i_mem_arbiter_if.slave bus
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sel_data_q;   // current winner: 1 = data side, 0 = fetch side
    logic                m_we_q;
    logic [BE_W-1:0]     m_be_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic [DATA_W-1:0]   m_wdata_q;
    logic [DATA_W-1:0]   i_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;

    logic                grant;
    logic                grant_data;
    logic                capture;
    logic                mem_en;
    logic                fetch_ack;
    logic                data_ack;

`ifdef ARB_ROUND_ROBIN_EN
    logic                last_data_q;  // last grant went to the data side

    // Contention goes to the side that was not granted last.
    always_comb begin
        grant_data = bus.d_req & ~(bus.i_req & last_data_q);
    end

    // Round-robin pointer, starts at "data" so the first contention goes to fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_data_q <= 1'b1;
        end else if (grant) begin
            last_data_q <= grant_data;
        end
    end
`else
    // Fixed priority: data over fetch.
    always_comb begin
        grant_data = bus.d_req;
    end
`endif

    // Next-state logic and per-state strobes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant     = 1'b0;
        capture   = 1'b0;
        mem_en    = 1'b0;
        fetch_ack = 1'b0;
        data_ack  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.i_req || bus.d_req) begin
                    grant   = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                mem_en = 1'b1;
                // m_we_q is only ever set by a data store grant.
                if (m_we_q) begin
                    state_d = StResp;
                end else begin
                    cnt_d   = CNT_W'(MEM_LAT);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    capture = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StResp: begin
                fetch_ack = ~sel_data_q;
                data_ack  = sel_data_q;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state and latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request fields latched at grant; read data captured when the latency expires.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_data_q <= 1'b0;
            m_we_q     <= 1'b0;
            m_be_q     <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (grant) begin
                sel_data_q <= grant_data;
                if (grant_data) begin
                    m_we_q    <= bus.d_we;
                    m_be_q    <= bus.d_we ? bus.d_be : '1;
                    m_addr_q  <= bus.d_addr;
                    m_wdata_q <= bus.d_wdata;
                end else begin
                    m_we_q   <= 1'b0;
                    m_be_q   <= '1;
                    m_addr_q <= bus.i_addr;
                end
            end
            if (capture) begin
                if (sel_data_q) begin
                    d_rdata_q <= bus.m_rdata;
                end else begin
                    i_rdata_q <= bus.m_rdata;
                end
            end
        end
    end

    assign bus.m_en    = mem_en;
    assign bus.m_we    = m_we_q;
    assign bus.m_be    = m_be_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.i_ack   = fetch_ack;
    assign bus.d_ack   = data_ack;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed bench for rv32i_mem_arbiter: three instances (MEM_LAT = 1, 2, 15), each with a
// small memory model whose read data is valid only in the cycle MEM_LAT after m_en.
module tb_rv32i_mem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    rv32i_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    rv32i_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
    rv32i_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

    rv32i_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    rv32i_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(2)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    rv32i_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(15)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h40) return 32'h0000_0013;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory models: junk except in the single cycle the data is due.
    logic [0:0]  sr0 = '0;
    logic [1:0]  sr1 = '0;
    logic [14:0] sr2 = '0;
    always @(posedge clk) begin
        sr0 <= bus0.m_en;
        sr1 <= {sr1[0], bus1.m_en};
        sr2 <= {sr2[13:0], bus2.m_en};
    end
    assign bus0.m_rdata = sr0[0]  ? mem_f(bus0.m_addr) : 32'hBAD0_BAD0;
    assign bus1.m_rdata = sr1[1]  ? mem_f(bus1.m_addr) : 32'hBAD0_BAD0;
    assign bus2.m_rdata = sr2[14] ? mem_f(bus2.m_addr) : 32'hBAD0_BAD0;

    task automatic clear_inputs();
        bus0.i_req = 0; bus0.i_addr = '0; bus0.d_req = 0; bus0.d_we = 0;
        bus0.d_be = '0; bus0.d_addr = '0; bus0.d_wdata = '0;
        bus1.i_req = 0; bus1.i_addr = '0; bus1.d_req = 0; bus1.d_we = 0;
        bus1.d_be = '0; bus1.d_addr = '0; bus1.d_wdata = '0;
        bus2.i_req = 0; bus2.i_addr = '0; bus2.d_req = 0; bus2.d_we = 0;
        bus2.d_be = '0; bus2.d_addr = '0; bus2.d_wdata = '0;
    endtask

    // Simultaneous fetch and data loads on the MEM_LAT=1 instance; each side drops its req on ack.
    task automatic contend(input string tag, input logic [31:0] ia, input logic [31:0] da,
                           input int exp_i, input int exp_d);
        int i_at = -1;
        int d_at = -1;
        int both = 0;
        bus0.d_we = 0; bus0.d_be = 4'hF; bus0.d_addr = da; bus0.i_addr = ia;
        bus0.d_req = 1; bus0.i_req = 1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (bus0.i_ack && bus0.d_ack) both++;
            if (bus0.d_ack && d_at < 0) begin
                d_at = n;
                bus0.d_req = 0;
            end
            if (bus0.i_ack && i_at < 0) begin
                i_at = n;
                bus0.i_req = 0;
            end
        end
        check({tag, "_i_ack_cycle"}, i_at, exp_i);
        check({tag, "_d_ack_cycle"}, d_at, exp_d);
        check({tag, "_i_rdata"}, bus0.i_rdata, mem_f(ia));
        check({tag, "_d_rdata"}, bus0.d_rdata, mem_f(da));
        check({tag, "_acks_overlap"}, both, 0);
    endtask

    initial begin
        int first_ack;
        int ack_cnt;
        int en_cnt;
        int ack_at [2];

        clear_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        check("reset0", {bus0.i_ack, bus0.d_ack, bus0.m_en, bus0.m_we, bus0.m_be, bus0.m_addr,
                         bus0.m_wdata, bus0.i_rdata, bus0.d_rdata}, '0);
        check("reset1", {bus1.i_ack, bus1.d_ack, bus1.m_en, bus1.m_we, bus1.m_be, bus1.m_addr,
                         bus1.m_wdata, bus1.i_rdata, bus1.d_rdata}, '0);
        check("reset2", {bus2.i_ack, bus2.d_ack, bus2.m_en, bus2.m_we, bus2.m_be, bus2.m_addr,
                         bus2.m_wdata, bus2.i_rdata, bus2.d_rdata}, '0);
        rst = 0;

        // Store on MEM_LAT=1 instance.
        bus0.d_req = 1; bus0.d_we = 1; bus0.d_be = 4'h3;
        bus0.d_addr = 32'h100; bus0.d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("st_issue", {bus0.m_en, bus0.m_we, bus0.m_be, bus0.m_addr, bus0.m_wdata, bus0.d_ack},
              {1'b1, 1'b1, 4'h3, 32'h100, 32'hDEAD_BEEF, 1'b0});
        bus0.d_wdata = 32'h0;  // ignored after grant
        @(negedge clk);
        check("st_ack", {bus0.d_ack, bus0.i_ack, bus0.m_en, bus0.m_wdata, bus0.d_rdata},
              {1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0});
        bus0.d_req = 0; bus0.d_we = 0;
        @(negedge clk);
        check("st_ack_width", {bus0.d_ack, bus0.m_en}, 2'b00);

        // Fetch on MEM_LAT=2 instance.
        bus1.i_addr = 32'h40; bus1.i_req = 1;
        first_ack = -1; ack_cnt = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check("f2_issue", {bus1.m_en, bus1.m_we, bus1.m_be, bus1.m_addr},
                      {1'b1, 1'b0, 4'hF, 32'h40});
            end
            if (bus1.i_ack) begin
                if (first_ack < 0) first_ack = n;
                ack_cnt++;
                bus1.i_req = 0;
            end
        end
        check("f2_ack_cycle", first_ack, 4);
        check("f2_ack_count", ack_cnt, 1);
        check("f2_rdata", bus1.i_rdata, 32'h0000_0013);

`ifdef ARB_ROUND_ROBIN_EN
        contend("rr_c1", 32'h300, 32'h200, 3, 7);
        contend("rr_c2", 32'h340, 32'h240, 3, 7);
`else
        contend("fp_c1", 32'h300, 32'h200, 7, 3);
        contend("fp_c2", 32'h340, 32'h240, 7, 3);
`endif

        // Fetch request held over two transactions.
        bus0.i_addr = 32'h44; bus0.i_req = 1;
        ack_cnt = 0; ack_at[0] = -1; ack_at[1] = -1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (bus0.i_ack) begin
                if (ack_cnt < 2) ack_at[ack_cnt] = n;
                ack_cnt++;
                if (ack_cnt == 2) bus0.i_req = 0;
            end
        end
        check("held_ack_count", ack_cnt, 2);
        check("held_ack0", ack_at[0], 3);
        check("held_ack1", ack_at[1], 7);
        check("held_rdata", bus0.i_rdata, mem_f(32'h44));

        // Reset while a data load is in WAIT.
        bus0.d_we = 0; bus0.d_be = 4'hF; bus0.d_addr = 32'h500; bus0.d_req = 1;
        @(negedge clk);
        check("rst_issue", bus0.m_en, 1'b1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("rst_outputs", {bus0.i_ack, bus0.d_ack, bus0.m_en, bus0.m_we, bus0.m_be,
                              bus0.m_addr, bus0.m_wdata, bus0.i_rdata, bus0.d_rdata}, '0);
        rst = 0; bus0.d_req = 0;
        ack_cnt = 0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (bus0.d_ack) ack_cnt++;
        end
        check("rst_no_d_ack", ack_cnt, 0);
        bus0.i_addr = 32'h40; bus0.i_req = 1;
        first_ack = -1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (bus0.i_ack && first_ack < 0) begin
                first_ack = n;
                bus0.i_req = 0;
            end
        end
        check("rst_fresh_ack_cycle", first_ack, 3);
        check("rst_fresh_rdata", bus0.i_rdata, 32'h0000_0013);

        // MEM_LAT=15 load.
        bus2.d_we = 0; bus2.d_be = 4'hF; bus2.d_addr = 32'h600; bus2.d_req = 1;
        first_ack = -1; ack_cnt = 0; en_cnt = 0;
        for (int n = 1; n <= 22; n++) begin
            @(negedge clk);
            if (bus2.m_en) en_cnt++;
            if (bus2.d_ack) begin
                if (first_ack < 0) first_ack = n;
                ack_cnt++;
                bus2.d_req = 0;
            end
        end
        check("l15_ack_cycle", first_ack, 17);
        check("l15_ack_count", ack_cnt, 1);
        check("l15_m_en_cycles", en_cnt, 1);
        check("l15_rdata", bus2.d_rdata, mem_f(32'h600));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
